// File: rtl/cms_topk_stage.sv
// Single-entry top-k filter stage: holds the best (key, value) seen so far and forwards the losers downstream.
// Optional feature: define CMS_TOPK_ACCUM_EN to sum values on key match instead of replacing them.
module cms_topk_stage #(
   parameter int KEY_WIDTH   = 32,
   parameter int VALUE_WIDTH = 32,
   parameter int MODE_MAX    = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_op,
   input  logic                   in_kv_valid,
   input  logic [KEY_WIDTH-1:0]   in_key,
   input  logic [VALUE_WIDTH-1:0] in_value,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             out_op,
   output logic                   out_kv_valid,
   output logic [KEY_WIDTH-1:0]   out_key,
   output logic [VALUE_WIDTH-1:0] out_value,
   output logic                   occupied,
   output logic [CNT_WIDTH-1:0]   swap_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_UPDATE = 2'b00,
      OP_DRAIN  = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_NOP    = 2'b11
   } op_t;

   state_t                 r_state;

   op_t                    r_op;
   logic                   r_kv_valid;
   logic [KEY_WIDTH-1:0]   r_key;
   logic [VALUE_WIDTH-1:0] r_value;

   logic [KEY_WIDTH-1:0]   r_held_key;
   logic [VALUE_WIDTH-1:0] r_held_value;
   logic                   r_occupied;
   logic [CNT_WIDTH-1:0]   r_swap_count;

   logic                   r_out_valid;
   op_t                    r_out_op;
   logic                   r_out_kv_valid;
   logic [KEY_WIDTH-1:0]   r_out_key;
   logic [VALUE_WIDTH-1:0] r_out_value;

   logic                   w_key_match;
   logic                   w_better;
   logic [VALUE_WIDTH-1:0] w_match_value;
   logic [CNT_WIDTH-1:0]   w_swap_next;

   assign w_key_match = (r_key == r_held_key);
   assign w_better    = (MODE_MAX != 0) ? (r_value > r_held_value) : (r_value < r_held_value);
   assign w_swap_next = (&r_swap_count) ? r_swap_count : r_swap_count + CNT_WIDTH'(1);

`ifdef CMS_TOPK_ACCUM_EN
   logic [VALUE_WIDTH:0] w_sum;
   assign w_sum         = {1'b0, r_held_value} + {1'b0, r_value};
   assign w_match_value = w_sum[VALUE_WIDTH] ? {VALUE_WIDTH{1'b1}} : w_sum[VALUE_WIDTH-1:0];
`else
   assign w_match_value = r_value;
`endif

   assign in_ready     = (r_state == ST_IDLE);
   assign out_valid    = r_out_valid;
   assign out_op       = r_out_op;
   assign out_kv_valid = r_out_kv_valid;
   assign out_key      = r_out_key;
   assign out_value    = r_out_value;
   assign occupied     = r_occupied;
   assign swap_count   = r_swap_count;

   // NOTE: all state uses non-blocking assignments, and the synchronous reset clears the held
   // pair too, so a reset mid-token leaves nothing stale for a later DRAIN to emit.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state        <= ST_IDLE;
         r_op           <= OP_UPDATE;
         r_kv_valid     <= 1'b0;
         r_key          <= '0;
         r_value        <= '0;
         r_held_key     <= '0;
         r_held_value   <= '0;
         r_occupied     <= 1'b0;
         r_swap_count   <= '0;
         r_out_valid    <= 1'b0;
         r_out_op       <= OP_UPDATE;
         r_out_kv_valid <= 1'b0;
         r_out_key      <= '0;
         r_out_value    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_op       <= op_t'(in_op);
                  r_kv_valid <= in_kv_valid;
                  r_key      <= in_key;
                  r_value    <= in_value;
                  r_state    <= ST_CMP;
               end
            end

            ST_CMP: begin
               r_state <= ST_IDLE;
               case (r_op)
                  OP_UPDATE: begin
                     if (r_kv_valid) begin
                        if (!r_occupied) begin
                           r_held_key   <= r_key;
                           r_held_value <= r_value;
                           r_occupied   <= 1'b1;
                        end else if (w_key_match) begin
                           r_held_value <= w_match_value;
                        end else if (w_better) begin
                           // The newcomer wins: the displaced pair goes downstream.
                           r_out_valid    <= 1'b1;
                           r_out_op       <= OP_UPDATE;
                           r_out_kv_valid <= 1'b1;
                           r_out_key      <= r_held_key;
                           r_out_value    <= r_held_value;
                           r_held_key     <= r_key;
                           r_held_value   <= r_value;
                           r_swap_count   <= w_swap_next;
                           r_state        <= ST_EMIT;
                        end else begin
                           r_out_valid    <= 1'b1;
                           r_out_op       <= OP_UPDATE;
                           r_out_kv_valid <= 1'b1;
                           r_out_key      <= r_key;
                           r_out_value    <= r_value;
                           r_state        <= ST_EMIT;
                        end
                     end
                  end

                  OP_DRAIN: begin
                     r_out_valid    <= 1'b1;
                     r_out_op       <= OP_DRAIN;
                     r_out_kv_valid <= r_occupied;
                     r_out_key      <= r_held_key;
                     r_out_value    <= r_held_value;
                     r_held_key     <= r_key;
                     r_held_value   <= r_value;
                     r_occupied     <= r_kv_valid;
                     r_state        <= ST_EMIT;
                  end

                  OP_CLEAR: begin
                     r_occupied     <= 1'b0;
                     r_out_valid    <= 1'b1;
                     r_out_op       <= OP_CLEAR;
                     r_out_kv_valid <= 1'b0;
                     r_out_key      <= '0;
                     r_out_value    <= '0;
                     r_state        <= ST_EMIT;
                  end

                  default: ;
               endcase
            end

            ST_EMIT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
